// File: rtl/msd_dimm_pkg.sv
// Shared types for the DDR5 channel command scheduler.
//   msd_cmd_t   : command encoding driven on cmd_type
//   msd_op_t    : request opcode encoding on req_op
//   msd_state_t : scheduler FSM states
//   address field positions and the queued request record
package msd_dimm_pkg;

    typedef enum logic [2:0] {
        CMD_ACT0 = 3'd0,
        CMD_ACT1 = 3'd1,
        CMD_RD0  = 3'd2,
        CMD_RD1  = 3'd3,
        CMD_WR0  = 3'd4,
        CMD_WR1  = 3'd5,
        CMD_PRE  = 3'd6
    } msd_cmd_t;

    typedef enum logic [1:0] {
        OP_RD     = 2'd0,
        OP_WR     = 2'd1,
        OP_IFETCH = 2'd2,
        OP_INV    = 2'd3
    } msd_op_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_ACT,
        ST_ACT0,
        ST_ACT1,
        ST_WAIT_CAS,
        ST_CAS0,
        ST_CAS1,
        ST_WAIT_PRE,
        ST_PRE
    } msd_state_t;

    // Physical address field positions
    localparam int ROW_LSB  = 18;
    localparam int ROW_MSB  = 33;
    localparam int COLH_LSB = 12;
    localparam int COLH_MSB = 17;
    localparam int COLL_LSB = 2;
    localparam int COLL_MSB = 5;
    localparam int BA_LSB   = 10;
    localparam int BA_MSB   = 11;
    localparam int BG_LSB   = 7;
    localparam int BG_MSB   = 9;

    typedef struct packed {
        msd_op_t     op;
        logic [15:0] row;
        logic [9:0]  col;
        logic [2:0]  bg;
        logic [1:0]  ba;
    } msd_req_t;

endpackage

// File: rtl/msd_bank_timer.sv
// One bank's activate/precharge spacing timers.
//   clk, rst  : clock, synchronous active-high reset
//   load_rc   : ACT0 issued to this bank this cycle (starts tRC window)
//   load_rp   : PRE issued to this bank this cycle (starts tRP window)
//   eligible  : bank may receive ACT0 this cycle
module msd_bank_timer #(
    parameter int T_RC = 115,
    parameter int T_RP = 39
) (
    input  logic clk,
    input  logic rst,
    input  logic load_rc,
    input  logic load_rp,
    output logic eligible
);

    // Width covers the larger window so a long tRP can never truncate.
    localparam int W = $clog2(((T_RC > T_RP) ? T_RC : T_RP) + 1);
    // Loaded with T-1 at the issuing edge so the counter reads zero
    // exactly T cycles after the command.
    localparam logic [W-1:0] RC_LD = W'(T_RC - 1);
    localparam logic [W-1:0] RP_LD = W'(T_RP - 1);

    logic [W-1:0] rc;
    logic [W-1:0] rp;

    always_ff @(posedge clk) begin
        if (rst) begin
            rc <= '0;
            rp <= '0;
        end else begin
            if (load_rc)        rc <= RC_LD;
            else if (rc != '0)  rc <= rc - 1'b1;
            if (load_rp)        rp <= RP_LD;
            else if (rp != '0)  rp <= rp - 1'b1;
        end
    end

    assign eligible = (rc == '0) && (rp == '0);

endmodule

// File: rtl/msd_cmd_scheduler.sv
// In-order, closed-page DDR5 command scheduler for one DIMM channel.
//   clk, rst         : command clock, synchronous active-high reset
//   req_valid/ready  : request handshake; req_op/req_addr request payload
//   cmd_valid, cmd_* : command bus (type, bank group, bank, row, column)
//   retire           : pulse on the PRE cycle that completes the head request
//   q_count          : request queue occupancy
import msd_dimm_pkg::*;

module msd_cmd_scheduler #(
    parameter int QDEPTH  = 16,
    parameter int T_RP    = 39,
    parameter int T_RCD   = 39,
    parameter int T_CL    = 40,
    parameter int T_BURST = 8,
    parameter int T_RTP   = 18,
    parameter int T_CWL   = 38,
    parameter int T_WR    = 30,
    parameter int T_RC    = 115
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_op,
    input  logic [35:0]               req_addr,
    output logic                      cmd_valid,
    output logic [2:0]                cmd_type,
    output logic [2:0]                cmd_bg,
    output logic [1:0]                cmd_ba,
    output logic [15:0]               cmd_row,
    output logic [9:0]                cmd_col,
    output logic                      retire,
    output logic [$clog2(QDEPTH):0]   q_count
);

    localparam int PW    = $clog2(QDEPTH);
    localparam int D_RD  = ((T_CL + T_BURST) > T_RTP) ? (T_CL + T_BURST) : T_RTP;
    localparam int D_WR  = T_CWL + T_BURST + T_WR;
    localparam int D_MAX = (D_WR > D_RD) ? ((D_WR > T_RCD) ? D_WR : T_RCD)
                                         : ((D_RD > T_RCD) ? D_RD : T_RCD);
    localparam int WCW   = $clog2(D_MAX + 1);
    localparam logic [WCW-1:0] LD_RCD = WCW'(T_RCD - 1);
    localparam logic [WCW-1:0] LD_RD  = WCW'(D_RD - 1);
    localparam logic [WCW-1:0] LD_WR  = WCW'(D_WR - 1);
    localparam logic [PW:0]    QFULL  = (PW+1)'(QDEPTH);

    // ---------------- request queue ----------------
    msd_req_t      mem [QDEPTH];
    msd_req_t      new_req;
    msd_req_t      head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          push;
    logic          pop;

    // Channel bit, top address bits and byte offset are not used for routing.
    logic unused_addr;
    assign unused_addr = ^{req_addr[35:34], req_addr[6], req_addr[1:0]};

    always_comb begin
        new_req.op  = msd_op_t'(req_op);
        new_req.row = req_addr[ROW_MSB:ROW_LSB];
        new_req.col = {req_addr[COLH_MSB:COLH_LSB], req_addr[COLL_MSB:COLL_LSB]};
        new_req.bg  = req_addr[BG_MSB:BG_LSB];
        new_req.ba  = req_addr[BA_MSB:BA_LSB];
    end

    // Readiness ignores a same-cycle retire so it stays a pure register decode.
    assign req_ready = (count < QFULL);
    assign push      = req_valid && req_ready && (req_op != 2'd3);
    assign head      = mem[rd_ptr];
    assign q_count   = count;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= new_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- per-bank timers ----------------
    logic [4:0]  head_bank;
    logic [31:0] elig;
    logic [31:0] ld_rc;
    logic [31:0] ld_rp;
    logic        act_issue;
    logic        pre_issue;

    assign head_bank = {head.bg, head.ba};
    assign ld_rc     = act_issue ? (32'd1 << head_bank) : 32'd0;
    assign ld_rp     = pre_issue ? (32'd1 << head_bank) : 32'd0;

    for (genvar i = 0; i < 32; i++) begin : g_bank
        msd_bank_timer #(.T_RC(T_RC), .T_RP(T_RP)) u_timer (
            .clk      (clk),
            .rst      (rst),
            .load_rc  (ld_rc[i]),
            .load_rp  (ld_rp[i]),
            .eligible (elig[i])
        );
    end

    // ---------------- FSM ----------------
    msd_state_t     state;
    msd_state_t     eff;
    msd_state_t     nxt;
    msd_cmd_t       ctype;
    logic [WCW-1:0] wcnt;
    logic [WCW-1:0] wval;
    logic           wload;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            wcnt  <= '0;
        end else begin
            state <= nxt;
            if (wload)            wcnt <= wval;
            else if (wcnt != '0)  wcnt <= wcnt - 1'b1;
        end
    end

    always_comb begin
        // Waiting states fall through to their action state in the cycle the
        // condition is met, so commands issue with no bubble cycle.
        eff = state;
        if (eff == ST_IDLE && count != '0)            eff = ST_WAIT_ACT;
        if (eff == ST_WAIT_ACT && elig[head_bank])    eff = ST_ACT0;
        if (eff == ST_WAIT_CAS && wcnt == '0)         eff = ST_CAS0;
        if (eff == ST_WAIT_PRE && wcnt == '0)         eff = ST_PRE;

        nxt       = eff;
        cmd_valid = 1'b0;
        ctype     = CMD_ACT0;
        cmd_bg    = '0;
        cmd_ba    = '0;
        cmd_row   = '0;
        cmd_col   = '0;
        retire    = 1'b0;
        wload     = 1'b0;
        wval      = '0;
        pop       = 1'b0;
        act_issue = 1'b0;
        pre_issue = 1'b0;

        case (eff)
            ST_ACT0: begin
                cmd_valid = 1'b1;
                ctype     = CMD_ACT0;
                cmd_bg    = head.bg;
                cmd_ba    = head.ba;
                cmd_row   = head.row;
                act_issue = 1'b1;
                wload     = 1'b1;
                wval      = LD_RCD;
                nxt       = ST_ACT1;
            end
            ST_ACT1: begin
                cmd_valid = 1'b1;
                ctype     = CMD_ACT1;
                cmd_bg    = head.bg;
                cmd_ba    = head.ba;
                cmd_row   = head.row;
                nxt       = ST_WAIT_CAS;
            end
            ST_CAS0: begin
                cmd_valid = 1'b1;
                ctype     = (head.op == OP_WR) ? CMD_WR0 : CMD_RD0;
                cmd_bg    = head.bg;
                cmd_ba    = head.ba;
                cmd_col   = head.col;
                wload     = 1'b1;
                wval      = (head.op == OP_WR) ? LD_WR : LD_RD;
                nxt       = ST_CAS1;
            end
            ST_CAS1: begin
                cmd_valid = 1'b1;
                ctype     = (head.op == OP_WR) ? CMD_WR1 : CMD_RD1;
                cmd_bg    = head.bg;
                cmd_ba    = head.ba;
                cmd_col   = head.col;
                nxt       = ST_WAIT_PRE;
            end
            ST_PRE: begin
                cmd_valid = 1'b1;
                ctype     = CMD_PRE;
                cmd_bg    = head.bg;
                cmd_ba    = head.ba;
                retire    = 1'b1;
                pop       = 1'b1;
                pre_issue = 1'b1;
                // A same-cycle push into an emptying queue is picked up by IDLE
                // on the next cycle with identical timing.
                nxt       = (count > 1) ? ST_WAIT_ACT : ST_IDLE;
            end
            default: ;
        endcase
    end

    assign cmd_type = ctype;

endmodule

// File: tb/tb_msd_cmd_scheduler.sv
// Self-checking bench for msd_cmd_scheduler: directed scenarios plus a
// randomized stream, compared against a request-level timing model.
module tb_msd_cmd_scheduler;
    import msd_dimm_pkg::*;

    localparam int T_RP = 39, T_RCD = 39, T_CL = 40, T_BURST = 8, T_RTP = 18;
    localparam int T_CWL = 38, T_WR = 30, T_RC = 115;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [35:0] req_addr = '0;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic [2:0]  cmd_bg;
    logic [1:0]  cmd_ba;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        retire;
    logic [4:0]  q_count;

    msd_cmd_scheduler dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .cmd_valid(cmd_valid),
        .cmd_type(cmd_type), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .retire(retire), .q_count(q_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] c;
        logic [2:0]  t;
        logic [2:0]  bg;
        logic [1:0]  ba;
        logic [15:0] row;
        logic [9:0]  col;
        logic        ret;
    } ev_t;

    ev_t obs[$];
    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    function automatic ev_t mk(input int c, input logic [2:0] t, input logic [2:0] bg,
                               input logic [1:0] ba, input logic [15:0] row,
                               input logic [9:0] col, input logic ret);
        ev_t e;
        e.c = c; e.t = t; e.bg = bg; e.ba = ba; e.row = row; e.col = col; e.ret = ret;
        return e;
    endfunction

    function automatic string fmt(input ev_t e);
        return $sformatf("c=%0d t=%0d bg=%0d ba=%0d row=%h col=%h ret=%0b",
                         e.c, e.t, e.bg, e.ba, e.row, e.col, e.ret);
    endfunction

    always @(negedge clk)
        if (rst === 1'b0 && (cmd_valid === 1'b1 || retire === 1'b1))
            obs.push_back(mk(cyc, cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col, retire));

    // ---------------- reference model ----------------
    // Each request: ACT0 at the earliest cycle after it is visible, after the
    // previous request's PRE, and outside its bank's tRP/tRC windows; the rest
    // of the sequence follows from the fixed command latencies.
    int m_lastpre[32];
    int m_lastact[32];
    int m_prev_pre;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_lastpre[i] = -100000;
            m_lastact[i] = -100000;
        end
        m_prev_pre = -100000;
        exp_q.delete();
    endtask

    task automatic model_req(input logic [35:0] addr, input logic [1:0] op, input int pc);
        int b, a, r, p, lat;
        logic [15:0] row;
        logic [9:0]  col;
        logic [2:0]  bg;
        logic [1:0]  ba;
        row = 16'((addr >> 18) % 65536);
        col = 10'((((addr >> 12) % 64) * 16) + ((addr >> 2) % 16));
        ba  = 2'((addr >> 10) % 4);
        bg  = 3'((addr >> 7) % 8);
        b   = bg * 4 + ba;
        a = pc + 1;
        if (m_prev_pre + 1 > a)       a = m_prev_pre + 1;
        if (m_lastpre[b] + T_RP > a)  a = m_lastpre[b] + T_RP;
        if (m_lastact[b] + T_RC > a)  a = m_lastact[b] + T_RC;
        r = a + T_RCD;
        if (op == 2'd1) lat = T_CWL + T_BURST + T_WR;
        else            lat = (T_CL + T_BURST > T_RTP) ? T_CL + T_BURST : T_RTP;
        p = r + lat;
        exp_q.push_back(mk(a,     CMD_ACT0, bg, ba, row, 10'd0, 1'b0));
        exp_q.push_back(mk(a + 1, CMD_ACT1, bg, ba, row, 10'd0, 1'b0));
        exp_q.push_back(mk(r,     (op == 2'd1) ? CMD_WR0 : CMD_RD0, bg, ba, 16'd0, col, 1'b0));
        exp_q.push_back(mk(r + 1, (op == 2'd1) ? CMD_WR1 : CMD_RD1, bg, ba, 16'd0, col, 1'b0));
        exp_q.push_back(mk(p,     CMD_PRE, bg, ba, 16'd0, 10'd0, 1'b1));
        m_lastact[b] = a;
        m_lastpre[b] = p;
        m_prev_pre   = p;
    endtask

    // ---------------- drivers ----------------
    // Called at a negedge; holds the request until accepted, returns the
    // acceptance cycle and leaves the bench at the next negedge.
    task automatic push(input logic [35:0] addr, input logic [1:0] op, output int acc);
        req_valid = 1'b1;
        req_addr  = addr;
        req_op    = op;
        acc = -1;
        for (int k = 0; k < 3000 && acc < 0; k++) begin
            if (req_ready) acc = cyc;
            @(negedge clk);
        end
        if (acc < 0) begin
            n_vec++; n_err++;
            $display("FAIL push_timeout addr=%h never accepted", addr);
        end
    endtask

    task automatic drain();
        int last;
        last = (exp_q.size() > 0) ? int'(exp_q[exp_q.size()-1].c) : cyc;
        req_valid = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            if (q_count == 0 && cyc > last + 2) return;
            @(negedge clk);
        end
        n_vec++; n_err++;
        $display("FAIL drain_timeout q_count=%0d required 0", q_count);
    endtask

    function automatic logic [35:0] mkaddr(input logic [15:0] row, input logic [2:0] bg,
                                           input logic [1:0] ba);
        logic [35:0] a;
        a = {$urandom, $urandom};
        a[33:18] = row;
        a[11:10] = ba;
        a[9:7]   = bg;
        return a;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({req_ready, cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col, retire, q_count}
            !== {1'b1, 1'b0, 3'd0, 3'd0, 2'd0, 16'd0, 10'd0, 1'b0, 5'd0}) begin
            n_err++;
            $display("FAIL reset_values rdy=%b v=%b t=%0d bg=%0d ba=%0d row=%h col=%h ret=%b q=%0d required rdy=1 rest 0",
                     req_ready, cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col, retire, q_count);
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_single(input logic [1:0] op, input string nm);
        int acc;
        obs.delete(); exp_q.delete();
        push(36'h000040000, op, acc);
        model_req(36'h000040000, op, acc);
        drain();
        n_vec++;
        if (obs.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL %s_count got %0d events required %0d", nm, obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_vec++;
            if (obs[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL %s_ev%0d got %s required %s", nm, i, fmt(obs[i]), fmt(exp_q[i]));
            end
        end
        n_vec++;
        if (q_count !== 5'd0) begin
            n_err++;
            $display("FAIL %s_qcount got %0d required 0", nm, q_count);
        end
    endtask

    task automatic test_pair(input logic [2:0] bg2, input string nm);
        int acc;
        logic [35:0] a1, a2;
        obs.delete(); exp_q.delete();
        a1 = mkaddr(16'h0001, 3'd0, 2'd0);
        a2 = mkaddr(16'h0002, bg2, 2'd0);
        push(a1, 2'd0, acc); model_req(a1, 2'd0, acc);
        push(a2, 2'd2, acc); model_req(a2, 2'd2, acc);
        drain();
        n_vec++;
        if (obs.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL %s_count got %0d events required %0d", nm, obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_vec++;
            if (obs[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL %s_ev%0d got %s required %s", nm, i, fmt(obs[i]), fmt(exp_q[i]));
            end
        end
    endtask

    task automatic test_full();
        int acc, first_pre;
        logic [35:0] a;
        obs.delete(); exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            a = mkaddr(16'($urandom), 3'(i % 8), 2'(i / 8));
            push(a, 2'd0, acc);
            model_req(a, 2'd0, acc);
        end
        req_valid = 1'b0;
        n_vec++;
        if (q_count !== 5'd16 || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_state q_count=%0d ready=%b required 16/0", q_count, req_ready);
        end
        first_pre = exp_q[4].c;
        a = mkaddr(16'h1234, 3'd3, 2'd3);
        push(a, 2'd1, acc);
        model_req(a, 2'd1, acc);
        n_vec++;
        if (acc != first_pre + 1) begin
            n_err++;
            $display("FAIL full_17th_accept got cycle %0d required %0d", acc, first_pre + 1);
        end
        drain();
        n_vec++;
        if (obs.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL full_count got %0d events required %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_vec++;
            if (obs[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL full_ev%0d got %s required %s", i, fmt(obs[i]), fmt(exp_q[i]));
            end
        end
    endtask

    task automatic test_invalid_and_reset();
        int acc;
        obs.delete(); exp_q.delete();
        push(36'h000040000, 2'd3, acc);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_vec++;
        if (q_count !== 5'd0 || obs.size() != 0) begin
            n_err++;
            $display("FAIL invalid_op q_count=%0d events=%0d required 0/0", q_count, obs.size());
        end
        // Abandon a sequence while it waits for tRCD.
        push(36'h000040000, 2'd0, acc);
        req_valid = 1'b0;
        for (int k = 0; k < 100 && cyc < acc + 10; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (cmd_valid !== 1'b0 || q_count !== 5'd0 || retire !== 1'b0) begin
            n_err++;
            $display("FAIL midop_reset v=%b q=%0d ret=%b required 0/0/0", cmd_valid, q_count, retire);
        end
        @(negedge clk);
        obs.delete();
        model_reset();
        push(36'h000040000, 2'd0, acc);
        model_req(36'h000040000, 2'd0, acc);
        drain();
        n_vec++;
        if (obs.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL post_reset_count got %0d events required %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_vec++;
            if (obs[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL post_reset_ev%0d got %s required %s", i, fmt(obs[i]), fmt(exp_q[i]));
            end
        end
    endtask

    task automatic test_random();
        int acc;
        logic [1:0]  op;
        logic [35:0] a;
        obs.delete(); exp_q.delete();
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = mkaddr(16'($urandom), 3'($urandom_range(0, 1)), 2'($urandom_range(0, 1)));
            push(a, op, acc);
            if (op != 2'd3) model_req(a, op, acc);
            req_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        n_vec++;
        if (obs.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL random_count got %0d events required %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_vec++;
            if (obs[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL random_ev%0d got %s required %s", i, fmt(obs[i]), fmt(exp_q[i]));
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single(2'd0, "single_read");
        test_single(2'd1, "single_write");
        test_pair(3'd0, "same_bank");
        test_pair(3'd1, "diff_bank");
        test_full();
        test_invalid_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
